// File: rtl/pipe_pe_ui_acc_if.sv
// Word stream handshake between the multiplier PE, the accumulator PE and the downstream consumer.
`timescale 1ns/1ps
interface pipe_pe_ui_acc_if #(
    parameter int N = 64
);
    logic         trigger;
    logic         cts;
    logic [N-1:0] in;
    logic         stall;
    logic [N-1:0] out;
    logic         ovalid;
    logic         sat;

    modport master (
        output trigger, in, stall,
        input  cts, out, ovalid, sat
    );

    modport slave (
        input  trigger, in, stall,
        output cts, out, ovalid, sat
    );
endinterface

// File: rtl/pipe_pe_ui_acc.sv
// Unsigned accumulator PE: emits one registered sum per LEN accepted words.
// Saturating accumulation is enabled by defining PIPE_PE_UI_ACC_SAT_EN.
`timescale 1ns/1ps
module pipe_pe_ui_acc #(
    parameter int N   = 64,
    parameter int LEN = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_pe_ui_acc_if.slave  bus
);
    localparam int            CW   = $clog2(LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    // RES_FULL means a finished sum sits on out; HOLD is RES_FULL while stalled.
    typedef enum logic {RES_EMPTY, RES_FULL} res_state_t;

    res_state_t    state;
    res_state_t    state_next;
    logic [N-1:0]  acc;
    logic [N-1:0]  out_q;
    logic [N-1:0]  sum;
    logic [CW-1:0] cnt;
    logic          cts_c;
    logic          ovalid_c;
    logic          accept;
    logic          last;

    assign accept = bus.trigger && cts_c;
    assign last   = accept && (cnt == LAST);

`ifdef PIPE_PE_UI_ACC_SAT_EN
    logic         carry;
    logic         sat_run;
    logic         sat_q;
    logic [N:0]   wide;

    always_comb begin
        wide  = {1'b0, acc} + {1'b0, bus.in};
        carry = wide[N];
        sum   = carry ? '1 : wide[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_run <= 1'b0;
            sat_q   <= 1'b0;
        end else if (last) begin
            sat_q   <= sat_run | carry;
            sat_run <= 1'b0;
        end else if (accept) begin
            sat_run <= sat_run | carry;
        end
    end

    assign bus.sat = sat_q;
`else
    assign sum     = acc + bus.in;
    assign bus.sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RES_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A new last word refills the output even in the cycle the old sum is consumed.
    always_comb begin
        state_next = state;
        if (last) begin
            state_next = RES_FULL;
        end else if ((state == RES_FULL) && !bus.stall) begin
            state_next = RES_EMPTY;
        end
    end

    always_comb begin
        ovalid_c = (state == RES_FULL);
        cts_c    = !((state == RES_FULL) && bus.stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else if (accept) begin
            if (cnt == LAST) begin
                out_q <= sum;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                acc   <= sum;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign bus.cts    = cts_c;
    assign bus.ovalid = ovalid_c;
    assign bus.out    = out_q;
endmodule

// File: tb/tb_pipe_pe_ui_acc.sv
// Directed bench for pipe_pe_ui_acc with N=8, LEN=4; follows PIPE_PE_UI_ACC_SAT_EN if defined.
`timescale 1ns/1ps
module tb_pipe_pe_ui_acc;
    localparam int N   = 8;
    localparam int LEN = 4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    pipe_pe_ui_acc_if #(.N(N)) bus ();

    pipe_pe_ui_acc #(.N(N), .LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic trig, input logic [N-1:0] data, input logic stl);
        bus.trigger = trig;
        bus.in      = data;
        bus.stall   = stl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic trig, input logic [N-1:0] data, input logic stl);
        apply_stimulus(trig, data, stl);
        tick();
    endtask

    task automatic check_word(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        apply_stimulus(1'b0, 8'd0, 1'b0);
        #12;
        check_word  ("reset_out",    bus.out,    8'd0);
        check_output("reset_ovalid", bus.ovalid, 1'b0);
        check_output("reset_sat",    bus.sat,    1'b0);
        check_output("reset_cts",    bus.cts,    1'b1);
        rst = 1'b0;

        $display("[TB] basic sum 1,2,3,4");
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b1, 8'd3, 1'b0);
        check_output("basic_early_ovalid", bus.ovalid, 1'b0);
        cycle(1'b1, 8'd4, 1'b0);
        check_word  ("basic_out",    bus.out,    8'd10);
        check_output("basic_ovalid", bus.ovalid, 1'b1);
        cycle(1'b0, 8'd0, 1'b0);
        check_output("basic_ovalid_clear", bus.ovalid, 1'b0);
        check_word  ("basic_out_hold",     bus.out,    8'd10);

        $display("[TB] back-to-back 1..8");
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, N'(i), 1'b0);
            #1;
            check_output("b2b_cts", bus.cts, 1'b1);
            tick();
            if (i == 4) begin
                check_word  ("b2b_out_first",    bus.out,    8'd10);
                check_output("b2b_ovalid_first", bus.ovalid, 1'b1);
            end else if (i == 8) begin
                check_word  ("b2b_out_second",    bus.out,    8'd26);
                check_output("b2b_ovalid_second", bus.ovalid, 1'b1);
            end else begin
                check_output("b2b_ovalid_idle", bus.ovalid, 1'b0);
            end
        end
        cycle(1'b0, 8'd0, 1'b0);

        $display("[TB] overflow 200,100,0,0");
        cycle(1'b1, 8'd200, 1'b0);
        cycle(1'b1, 8'd100, 1'b0);
        cycle(1'b1, 8'd0,   1'b0);
        cycle(1'b1, 8'd0,   1'b0);
        check_output("ovf_ovalid", bus.ovalid, 1'b1);
`ifdef PIPE_PE_UI_ACC_SAT_EN
        check_word  ("ovf_out", bus.out, 8'd255);
        check_output("ovf_sat", bus.sat, 1'b1);
`else
        check_word  ("ovf_out", bus.out, 8'd44);
        check_output("ovf_sat", bus.sat, 1'b0);
`endif
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        check_word  ("after_ovf_out", bus.out, 8'd4);
        check_output("after_ovf_sat", bus.sat, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);

        $display("[TB] stall with pending result");
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        check_word("stall_pre_out", bus.out, 8'd8);
        apply_stimulus(1'b1, 8'd50, 1'b1);
        #1;
        check_output("stall_cts_drop", bus.cts, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word  ("stall_out_hold",    bus.out,    8'd8);
            check_output("stall_ovalid_hold", bus.ovalid, 1'b1);
            check_output("stall_cts_low",     bus.cts,    1'b0);
        end
        apply_stimulus(1'b1, 8'd3, 1'b0);
        #1;
        check_output("stall_cts_rise", bus.cts, 1'b1);
        tick();
        check_output("stall_consumed", bus.ovalid, 1'b0);
        cycle(1'b1, 8'd3, 1'b0);
        cycle(1'b1, 8'd3, 1'b0);
        cycle(1'b1, 8'd3, 1'b0);
        check_word  ("stall_next_out",    bus.out,    8'd12);
        check_output("stall_next_ovalid", bus.ovalid, 1'b1);
        cycle(1'b0, 8'd0, 1'b0);

        $display("[TB] gapped input 5,_,7,_,_,9,1");
        cycle(1'b1, 8'd5,  1'b0);
        cycle(1'b0, 8'd77, 1'b0);
        cycle(1'b1, 8'd7,  1'b0);
        cycle(1'b0, 8'd77, 1'b0);
        cycle(1'b0, 8'd77, 1'b0);
        cycle(1'b1, 8'd9,  1'b0);
        check_output("gap_early_ovalid", bus.ovalid, 1'b0);
        cycle(1'b1, 8'd1,  1'b0);
        check_word  ("gap_out",    bus.out,    8'd22);
        check_output("gap_ovalid", bus.ovalid, 1'b1);

        $display("[TB] asynchronous reset mid-reduction");
        cycle(1'b1, 8'd4, 1'b0);
        cycle(1'b1, 8'd4, 1'b0);
        apply_stimulus(1'b0, 8'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_word  ("arst_out",    bus.out,    8'd0);
        check_output("arst_ovalid", bus.ovalid, 1'b0);
        check_output("arst_sat",    bus.sat,    1'b0);
        check_output("arst_cts",    bus.cts,    1'b1);
        #1;
        rst = 1'b0;
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        check_output("arst_early_ovalid", bus.ovalid, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        check_word  ("arst_next_out",    bus.out,    8'd4);
        check_output("arst_next_ovalid", bus.ovalid, 1'b1);
        cycle(1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
